// File: rtl/dial_pkg.sv
// dial_pkg: shared types and constants for the dial spinner.
// FSM states, decoded commands, widths and the position step helper.
package dial_pkg;

  localparam int DIAL_POS_W = 4;
  localparam int DIAL_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    CRUISE
  } dial_state_e;

  typedef enum logic [1:0] {
    NONE,
    LEFT,
    RIGHT
  } dial_cmd_e;

  localparam logic [DIAL_POS_W-1:0] POS_ONE = 1;

  function automatic logic [DIAL_POS_W-1:0] pos_step(
    input logic [DIAL_POS_W-1:0] pos,
    input logic                  right
  );
    return right ? pos + POS_ONE : pos - POS_ONE;
  endfunction

endpackage

// File: rtl/dial_rate_ctr.sv
// dial_rate_ctr: ce-counted step timer with period halving.
// Ports: clk, rst_n, ce, load, clr, run, halve -> step_due, at_min.
module dial_rate_ctr
  import dial_pkg::*;
#(
  parameter int TICK_DIV = 16,
  parameter int MIN_DIV  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic load,
  input  logic clr,
  input  logic run,
  input  logic halve,
  output logic step_due,
  output logic at_min
);

  localparam logic [DIAL_CNT_W-1:0] TICK_P = DIAL_CNT_W'(TICK_DIV);
  localparam logic [DIAL_CNT_W-1:0] MIN_P  = DIAL_CNT_W'(MIN_DIV);
  localparam logic [DIAL_CNT_W-1:0] ONE    = 1;

  logic [DIAL_CNT_W-1:0] count;
  logic [DIAL_CNT_W-1:0] period;
  logic [DIAL_CNT_W-1:0] half;

  always_comb begin
    half = period >> 1;
    if (half < MIN_P) half = MIN_P;
  end

  // Step is due when this ce completes the period;
  // the owner decides whether it is running.
  assign step_due = (count + ONE == period);
  assign at_min   = (half == MIN_P);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      period <= TICK_P;
    end else if (ce) begin
      if (load) begin
        count  <= '0;
        period <= TICK_P;
      end else if (clr) begin
        count <= '0;
      end else if (run) begin
        if (step_due) begin
          count <= '0;
          if (halve) period <= half;
        end else begin
          count <= count + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/dial_spinner.sv
// dial_spinner: accelerating rotary dial emulation from left/right levels.
// Ports: clk, RESET_N, ce, move_left, move_right -> dial_out {dir, pos[3:0]}.
// Acceleration is enabled by defining DIAL_SPINNER_ACCEL_EN.
module dial_spinner
  import dial_pkg::*;
#(
  parameter int TICK_DIV = 16,
  parameter int MIN_DIV  = 4
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic       ce,
  input  logic       move_left,
  input  logic       move_right,
  output logic [4:0] dial_out
);

`ifdef DIAL_SPINNER_ACCEL_EN
  localparam bit ACCEL_EN = 1'b1;
`else
  localparam bit ACCEL_EN = 1'b0;
`endif

  dial_state_e           state, state_n;
  dial_cmd_e             cmd;
  logic [DIAL_POS_W-1:0] pos, pos_n;
  logic                  dir, dir_n;
  logic                  entry;
  logic                  load, clr, run, halve;
  logic                  step_due, at_min;

  always_comb begin
    cmd = NONE;
    unique case (1'b1)
      (move_right & ~move_left): cmd = RIGHT;
      (move_left & ~move_right): cmd = LEFT;
      default:                   cmd = NONE;
    endcase
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    dir_n   = dir;
    load    = 1'b0;
    clr     = 1'b0;
    run     = 1'b0;
    halve   = 1'b0;
    // A reversal restarts motion exactly like a fresh entry.
    entry   = (cmd != NONE) &&
              ((state == IDLE) || ((cmd == RIGHT) != dir));
    if (ce) begin
      if (cmd == NONE) begin
        if (state != IDLE) begin
          clr     = 1'b1;
          state_n = IDLE;
        end
      end else if (entry) begin
        pos_n   = pos_step(pos, cmd == RIGHT);
        dir_n   = (cmd == RIGHT);
        load    = 1'b1;
        state_n = RAMP;
      end else begin
        run   = 1'b1;
        halve = ACCEL_EN && (state == RAMP);
        if (step_due) begin
          pos_n = pos_step(pos, dir);
          if (halve && at_min) state_n = CRUISE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      pos   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      dir   <= dir_n;
    end
  end

  assign dial_out = {dir, pos};

  dial_rate_ctr #(
    .TICK_DIV (TICK_DIV),
    .MIN_DIV  (MIN_DIV)
  ) u_rate (
    .clk      (clk),
    .rst_n    (RESET_N),
    .ce       (ce),
    .load     (load),
    .clr      (clr),
    .run      (run),
    .halve    (halve),
    .step_due (step_due),
    .at_min   (at_min)
  );

endmodule
